// File: rtl/button_pkg.sv
// Shared press timing constants and state encoding for the button
// emulator and the press decoder it feeds.
package button_pkg;

  localparam int DEBOUNCE_P        = 300;
  localparam int SWITCH_MODE_MIN_T = 5000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } press_state_e;

endpackage

// File: rtl/button_press_gen_if.sv
// Request/abort inputs and emulated button outputs of the press
// generator, bundled for the driver (master) and the generator (slave).
interface button_press_gen_if;
  import button_pkg::*;

  logic req_short;
  logic req_long;
  logic abort;
  logic push_button;
  logic busy;
  logic done;

  modport master (
    output req_short,
    output req_long,
    output abort,
    input  push_button,
    input  busy,
    input  done
  );

  modport slave (
    input  req_short,
    input  req_long,
    input  abort,
    output push_button,
    output busy,
    output done
  );

endinterface

// File: rtl/button_press_gen.sv
// Emulates a push button: one short or long press on request, then a
// fixed low gap, with a done pulse on the first idle cycle after it.
module button_press_gen
  import button_pkg::*;
#(
  parameter int SHORT_HOLD = 1000,
  parameter int LONG_HOLD  = 6000,
  parameter int GAP        = 400,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         rst,
  button_press_gen_if.slave bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_HOLD = ST_HOLD;
  localparam logic [1:0] S_GAP  = ST_GAP;

  // terminal counts are stored as len-1 so the compare is direct
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_HOLD - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_last;
  logic             push_q;
  logic             busy_q;
  logic             done_q;

  logic in_idle;
  logic in_hold;
  logic in_gap;
  logic req_any;
  logic hold_end;
  logic gap_end;

  assign in_idle  = (state == S_IDLE);
  assign in_hold  = (state == S_HOLD);
  assign in_gap   = (state == S_GAP);
  assign req_any  = bus.req_short | bus.req_long;
  assign hold_end = bus.abort | (cnt == hold_last);
  assign gap_end  = (cnt == GAP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold_last <= '0;
      push_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        in_idle: begin
          if (req_any) begin
            hold_last <= bus.req_long ? LONG_LAST
                                      : SHORT_LAST;
            cnt       <= '0;
            state     <= S_HOLD;
            push_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        in_hold: begin
          if (hold_end) begin
            state  <= S_GAP;
            cnt    <= '0;
            push_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        in_gap: begin
          if (gap_end) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          push_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.push_button = push_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_button_press_gen.sv
// Bench for button_press_gen: per-cycle waveform of {push,busy,done}
// compared with one built from press start/length/gap arithmetic.
module tb_button_press_gen;
  import button_pkg::*;

  localparam int SH = 1000;
  localparam int LH = 6000;
  localparam int GP = 400;
  localparam int P  = SH + GP + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_press_gen_if bus();

  button_press_gen #(
    .SHORT_HOLD(SH),
    .LONG_HOLD (LH),
    .GAP       (GP),
    .CNT_W     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0] ol[$];
  logic [2:0] el[$];

  function automatic void exp_init(int n);
    el.delete();
    repeat (n) el.push_back(3'b000);
  endfunction

  // press whose first high cycle is s, high for h cycles
  function automatic void exp_press(int s, int h);
    for (int c = s; c <= s + h + GP; c++) begin
      if (c - 1 < el.size()) begin
        if (c < s + h)
          el[c-1] = 3'b110;
        else if (c < s + h + GP)
          el[c-1] = 3'b010;
        else
          el[c-1] = 3'b001;
      end
    end
  endfunction

  function automatic int first_diff();
    if (ol.size() != el.size()) return 0;
    for (int i = 0; i < el.size(); i++)
      if (ol[i] !== el[i]) return i;
    return -1;
  endfunction

  function automatic int press_class(int h);
    if (h > DEBOUNCE_P + SWITCH_MODE_MIN_T + 1) return 2;
    if (h > DEBOUNCE_P && h < DEBOUNCE_P + SWITCH_MODE_MIN_T)
      return 1;
    return 0;
  endfunction

  // pushes seen by the decoder and length of the last one
  function automatic void push_runs(output int runs, output int len);
    logic prev;
    prev = 1'b0;
    runs = 0;
    len  = 0;
    foreach (ol[i]) begin
      if (ol[i][2] === 1'b1) begin
        if (prev !== 1'b1) begin
          runs++;
          len = 0;
        end
        len++;
      end
      prev = ol[i][2];
    end
  endfunction

  function automatic logic [2:0] outs();
    return {bus.push_button, bus.busy, bus.done};
  endfunction

  task automatic idle_inputs();
    bus.req_short = 1'b0;
    bus.req_long  = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    n_assert++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b expected 0", nm, bus.busy);
    end
  endtask

  // request at edge 0, abort held at edge 0 (idle, must be ignored),
  // optional abort at cycle ab, optional noise on ignored inputs
  task automatic drive_press(input bit s, input bit l, input int ab,
                             input int heff, input bit noise);
    int n;
    n = heff + GP + 2;
    ol.delete();
    exp_init(n);
    exp_press(1, heff);
    bus.req_short = s;
    bus.req_long  = l;
    bus.abort     = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      ol.push_back(outs());
      bus.abort = (c == ab) ||
                  (noise && c > heff && c <= heff + GP &&
                   $urandom_range(0, 1) == 1);
      if (noise && c <= heff + GP) begin
        bus.req_short = ($urandom_range(0, 1) == 1);
        bus.req_long  = ($urandom_range(0, 1) == 1);
      end else begin
        bus.req_short = 1'b0;
        bus.req_long  = 1'b0;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    n_assert++;
    if (outs() !== 3'b000) begin
      n_fail++;
      $display("FAIL reset outs: pbd=%b expected 000", outs());
    end
    bus.req_long = 1'b1;
    @(negedge clk);
    n_assert++;
    if (outs() !== 3'b000) begin
      n_fail++;
      $display("FAIL reset req: pbd=%b expected 000", outs());
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_short();
    int d, runs, len;
    drive_press(1'b1, 1'b0, 0, SH, 1'b0);
    d = first_diff();
    n_assert++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL short wave: cycle %0d pbd=%b expected %b",
               d + 1, ol[d], el[d]);
    end
    push_runs(runs, len);
    n_assert++;
    if (runs != 1 || press_class(len) != 1) begin
      n_fail++;
      $display("FAIL short decode: runs=%0d len=%0d expected 1 B",
               runs, len);
    end
    wait_idle("short");
  endtask

  task automatic test_long();
    int d, runs, len;
    drive_press(1'b0, 1'b1, 0, LH, 1'b0);
    d = first_diff();
    n_assert++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL long wave: cycle %0d pbd=%b expected %b",
               d + 1, ol[d], el[d]);
    end
    push_runs(runs, len);
    n_assert++;
    if (runs != 1 || press_class(len) != 2) begin
      n_fail++;
      $display("FAIL long decode: runs=%0d len=%0d expected 1 A",
               runs, len);
    end
    wait_idle("long");
  endtask

  task automatic test_both();
    int d, runs, len;
    drive_press(1'b1, 1'b1, 0, LH, 1'b1);
    d = first_diff();
    n_assert++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL both wave: cycle %0d pbd=%b expected %b",
               d + 1, ol[d], el[d]);
    end
    push_runs(runs, len);
    n_assert++;
    if (runs != 1 || len != LH) begin
      n_fail++;
      $display("FAIL both len: runs=%0d len=%0d expected 1 %0d",
               runs, len, LH);
    end
    wait_idle("both");
  endtask

  task automatic test_abort();
    int d;
    drive_press(1'b1, 1'b0, 100, 100, 1'b1);
    d = first_diff();
    n_assert++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL abort wave: cycle %0d pbd=%b expected %b",
               d + 1, ol[d], el[d]);
    end
    wait_idle("abort");
  endtask

  task automatic test_back_to_back();
    int d, n;
    n = 3 * P;
    ol.delete();
    exp_init(n);
    for (int k = 0; k < 3; k++) exp_press(1 + k * P, SH);
    bus.req_short = 1'b1;
    bus.abort     = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      ol.push_back(outs());
      bus.req_long = (c == 50);
    end
    idle_inputs();
    d = first_diff();
    n_assert++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL b2b wave: cycle %0d pbd=%b expected %b",
               d + 1, ol[d], el[d]);
    end
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid_hold();
    int d;
    bus.req_short = 1'b1;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      bus.req_short = 1'b0;
    end
    n_assert++;
    if (outs() !== 3'b110) begin
      n_fail++;
      $display("FAIL rst pre: pbd=%b expected 110", outs());
    end
    rst = 1'b1;
    #1;
    n_assert++;
    if (outs() !== 3'b000) begin
      n_fail++;
      $display("FAIL rst async: pbd=%b expected 000", outs());
    end
    @(negedge clk);
    rst = 1'b0;
    drive_press(1'b1, 1'b0, 0, SH, 1'b0);
    d = first_diff();
    n_assert++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL rst after: cycle %0d pbd=%b expected %b",
               d + 1, ol[d], el[d]);
    end
    wait_idle("rst");
  endtask

  task automatic test_random();
    int d, kind, h, ab, heff;
    bit s, l;
    for (int it = 0; it < 4; it++) begin
      kind = $urandom_range(0, 2);
      l    = (kind != 0);
      s    = (kind != 1);
      h    = l ? LH : SH;
      ab   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, h) : 0;
      heff = (ab != 0) ? ab : h;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      drive_press(s, l, ab, heff, 1'b1);
      d = first_diff();
      n_assert++;
      if (d != -1) begin
        n_fail++;
        $display("FAIL rand%0d wave: s=%0b l=%0b ab=%0d cycle %0d pbd=%b expected %b",
                 it, s, l, ab, d + 1, ol[d], el[d]);
      end
      wait_idle("rand");
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_short();
    test_long();
    test_both();
    test_abort();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
